// File: rtl/cla_defs_pkg.sv
// cla_defs: shared definitions for the nibble-serial CLA adder.
//   NIBBLE_W  width of the shared cla slice
//   state_t   sequencer states (encodings are fixed; debug tools decode them)
package cla_defs;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/cla4.sv
// cla4: 4-bit carry-lookahead adder slice, purely combinational.
//   a, b  in   4  addends
//   cin   in   1  carry in
//   s     out  4  sum
//   cout  out  1  carry out of bit 3
module cla4
   import cla_defs::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] s,
   output logic                cout
);

   logic [NIBBLE_W-1:0] g;
   logic [NIBBLE_W-1:0] p;
   logic c1, c2, c3;

   assign g = a & b;
   assign p = a ^ b;

   // Every carry is flattened to generate/propagate terms, no ripple path.
   assign c1   = g[0] | (p[0] & cin);
   assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);
   assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

   assign s = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/cla_serial_adder_ctrl.sv
// cla_serial_adder_ctrl: adds two WIDTH-bit operands nibble-serially through
// a single shared cla4 slice, LSB nibble first, carry held in a register.
//   clk, rst     clock, synchronous active-high reset
//   start_valid  in   request present (a, b, cin valid)
//   start_ready  out  request accepted when high (IDLE only)
//   a, b, cin    in   operands, sampled only on the accept edge
//   res_valid    out  sum/cout hold a completed result (DONE)
//   res_ready    in   consumer takes the result
//   sum, cout    out  registered (a+b+cin) mod 2^WIDTH and carry out
//   busy         out  high in RUN or DONE
//   fsm_state    out  current sequencer state, for observation only
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. start_ready depends only on state; res_valid depends only on
// state. Requests seen outside IDLE and res_ready seen outside DONE are
// ignored. Retiring a result and accepting a new request never share an edge.
module cla_serial_adder_ctrl
   import cla_defs::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy,
   output logic [1:0]       fsm_state
);

   localparam int NIB = WIDTH / NIBBLE_W;
   localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

   // Unsupported widths reference a module that does not exist.
   generate
      if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_width_illegal
         cla_serial_adder_ctrl_width_must_be_multiple_of_4 u_bad ();
      end
   endgenerate

   state_t state, state_nxt;

   logic [WIDTH-1:0]    a_sh, b_sh, res_sh, res_nxt;
   logic                carry;
   logic [CW-1:0]       cnt;
   logic                last;
   logic [NIBBLE_W-1:0] s_nib;
   logic                c_nib;

   cla4 u_cla (
      .a    (a_sh[NIBBLE_W-1:0]),
      .b    (b_sh[NIBBLE_W-1:0]),
      .cin  (carry),
      .s    (s_nib),
      .cout (c_nib)
   );

   assign last = (cnt == CW'(NIB - 1));

   // New nibble enters at the MSB end, so after NIB steps nibble 0 sits at
   // the bottom. Written as shift/or so WIDTH==4 needs no special slice.
   assign res_nxt = (res_sh >> NIBBLE_W) | (WIDTH'(s_nib) << (WIDTH - NIBBLE_W));

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start_valid) state_nxt = ST_RUN;
         ST_RUN:  if (last)        state_nxt = ST_DONE;
         ST_DONE: if (res_ready)   state_nxt = ST_IDLE;
         default:                  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum    <= '0;
         cout   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_valid) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  carry <= cin;
                  cnt   <= '0;
               end
            end
            ST_RUN: begin
               a_sh   <= a_sh >> NIBBLE_W;
               b_sh   <= b_sh >> NIBBLE_W;
               res_sh <= res_nxt;
               carry  <= c_nib;
               cnt    <= cnt + CW'(1);
               if (last) begin
                  sum  <= res_nxt;
                  cout <= c_nib;
               end
            end
            default: ;
         endcase
      end
   end

   assign start_ready = (state == ST_IDLE);
   assign res_valid   = (state == ST_DONE);
   assign busy        = (state != ST_IDLE);
   assign fsm_state   = state;

endmodule

// File: tb/tb_cla_serial_adder_ctrl.sv
module tb_cla_serial_adder_ctrl;

  localparam int NIB16 = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        start_valid, start_ready, res_valid, res_ready, cin, cout, busy;
  logic [15:0] a, b, sum;
  logic [1:0]  fsm_state;

  // 4-bit instance
  logic       start_valid4, start_ready4, res_valid4, res_ready4, cin4, cout4, busy4;
  logic [3:0] a4, b4, sum4;
  logic [1:0] fsm_state4;

  cla_serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .a(a), .b(b), .cin(cin),
    .res_valid(res_valid), .res_ready(res_ready),
    .sum(sum), .cout(cout), .busy(busy), .fsm_state(fsm_state)
  );

  cla_serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .start_valid(start_valid4), .start_ready(start_ready4),
    .a(a4), .b(b4), .cin(cin4),
    .res_valid(res_valid4), .res_ready(res_ready4),
    .sum(sum4), .cout(cout4), .busy(busy4), .fsm_state(fsm_state4)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [16:0] exp_q[$];   // {cout, sum}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // reference model: plain integer addition
  function automatic logic [16:0] model_add(input logic [15:0] x, input logic [15:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + 17'(c);
  endfunction

  // ---------------- driver tasks ----------------
  // Waits (bounded) for res_valid after an accept edge, checks latency and
  // result, optionally stalls the consumer, then retires the result.
  task automatic wait_result(input string name, input bit noisy);
    int n;
    logic [16:0] expv;
    n = 0;
    while (!res_valid && n < 20) begin
      @(posedge clk); n++; @(negedge clk);
      if (noisy) begin
        start_valid = 1'($urandom_range(0, 1));
        res_ready   = 1'($urandom_range(0, 1));
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom_range(0, 1));
      end
    end
    start_valid = 1'b0;
    res_ready   = 1'b0;
    check({name, "_latency"}, n, NIB16);
    expv = (exp_q.size() != 0) ? exp_q.pop_front() : 17'h0;
    check({name, "_result"}, {cout, sum}, expv);
    repeat ($urandom_range(0, 2)) begin
      @(posedge clk); @(negedge clk);
      check({name, "_hold"}, {res_valid, cout, sum}, {1'b1, expv});
    end
    res_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    res_ready = 1'b0;
    check({name, "_retire"}, {busy, res_valid, start_ready}, 3'b001);
  endtask

  task automatic run_op(input string name, input logic [15:0] ta, input logic [15:0] tb,
                        input logic tcin, input logic [16:0] expv, input bit noisy);
    logic [16:0] prev;
    @(negedge clk);
    check({name, "_idle_ready"}, start_ready, 1'b1);
    prev = {cout, sum};
    a = ta; b = tb; cin = tcin; start_valid = 1'b1;
    exp_q.push_back(expv);
    @(posedge clk);
    @(negedge clk);
    start_valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    res_ready   = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom_range(0, 1));
    check({name, "_run_flags"}, {busy, start_ready, res_valid}, 3'b100);
    check({name, "_run_sum_hold"}, {cout, sum}, prev);
    wait_result(name, noisy);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs[7];

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
  } vec4_t;

  vec4_t vecs4[3];

  initial begin
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[2] = '{16'h000D, 16'h000B, 1'b0, 16'h0018, 1'b0};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};

    vecs4[0] = '{4'hD, 4'hB, 1'b0, 4'h8, 1'b1};
    vecs4[1] = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b1};
    vecs4[2] = '{4'h3, 4'h4, 1'b1, 4'h8, 1'b0};

    // reset
    rst = 1'b1;
    start_valid = 0; res_ready = 0; a = 0; b = 0; cin = 0;
    start_valid4 = 0; res_ready4 = 0; a4 = 0; b4 = 0; cin4 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset16", {start_ready, res_valid, busy, cout, sum}, {4'b1000, 16'h0});
    check("reset4", {start_ready4, res_valid4, busy4, cout4, sum4}, {4'b1000, 4'h0});
    rst = 1'b0;

    // table-driven directed vectors
    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
             {vecs[i].cout, vecs[i].sum}, 1'b0);

    // consumer stall with a pending request in DONE
    begin
      int n;
      @(negedge clk);
      a = 16'h1234; b = 16'h4321; cin = 1'b0; start_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      start_valid = 1'b0;
      n = 0;
      while (!res_valid && n < 20) begin @(posedge clk); n++; @(negedge clk); end
      check("stall_latency", n, NIB16);
      a = 16'h0101; b = 16'h0202; cin = 1'b0; start_valid = 1'b1;
      repeat (5) begin
        @(posedge clk); @(negedge clk);
        check("stall_hold", {res_valid, start_ready, cout, sum}, {3'b100, 16'h5555});
      end
      res_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      res_ready = 1'b0;
      check("stall_retire", {busy, res_valid, start_ready, cout, sum}, {4'b0010, 16'h5555});
      exp_q.push_back(17'h00303);
      @(posedge clk); @(negedge clk);
      start_valid = 1'b0;
      check("stall_accept", {busy, start_ready}, 2'b10);
      wait_result("stall_next", 1'b0);
    end

    // reset during the second RUN cycle
    begin
      bit seen;
      @(negedge clk);
      a = 16'hAAAA; b = 16'h1111; cin = 1'b1; start_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      start_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b0;
      check("abort_state", {start_ready, res_valid, busy, cout, sum}, {4'b1000, 16'h0});
      seen = 1'b0;
      repeat (6) begin @(posedge clk); @(negedge clk); if (res_valid) seen = 1'b1; end
      check("abort_no_result", seen, 1'b0);
      run_op("after_abort", 16'h1234, 16'h4321, 1'b0, 17'h05555, 1'b0);
    end

    // randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra, rb;
      logic rc;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      if (i % 8 == 0) rb = ~ra;   // full carry-chain candidates
      run_op($sformatf("rand%0d", i), ra, rb, rc, model_add(ra, rb, rc), 1'b1);
    end

    // WIDTH=4 instance: single-nibble operation
    foreach (vecs4[i]) begin
      int n;
      @(negedge clk);
      check("w4_idle_ready", start_ready4, 1'b1);
      a4 = vecs4[i].a; b4 = vecs4[i].b; cin4 = vecs4[i].cin; start_valid4 = 1'b1;
      @(posedge clk); @(negedge clk);
      start_valid4 = 1'b0;
      a4 = 4'($urandom); b4 = 4'($urandom);
      n = 0;
      while (!res_valid4 && n < 10) begin @(posedge clk); n++; @(negedge clk); end
      check("w4_latency", n, 1);
      check("w4_result", {cout4, sum4}, {vecs4[i].cout, vecs4[i].sum});
      res_ready4 = 1'b1;
      @(posedge clk); @(negedge clk);
      res_ready4 = 1'b0;
      check("w4_retire", {busy4, res_valid4, start_ready4}, 3'b001);
    end

    check("queue_empty", exp_q.size(), 0);

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
